// File: rtl/mac_rx_writer_if.sv
// mac_rx_writer_if
// Streaming receive bus from the MAC into the FIFO writer.
//   mac_valid / mac_ready : handshake; a beat moves when both are high
//   mac_sop / mac_eop     : first / last beat of a packet
//   mac_error             : MAC error flag, may be set on any beat
//   mac_data              : beat payload, DATA_W bits
// master = MAC side (drives the beat), slave = writer side (drives ready).
interface mac_rx_writer_if #(
   parameter int DATA_W = 32
);
   logic              mac_valid;
   logic              mac_sop;
   logic              mac_eop;
   logic              mac_error;
   logic [DATA_W-1:0] mac_data;
   logic              mac_ready;

   modport master (
      output mac_valid, mac_sop, mac_eop, mac_error, mac_data,
      input  mac_ready
   );

   modport slave (
      input  mac_valid, mac_sop, mac_eop, mac_error, mac_data,
      output mac_ready
   );
endinterface

// File: rtl/mac_rx_writer.sv
// mac_rx_writer
// Packs MAC receive beats into input-FIFO words {err, eop, data}, applies
// FIFO backpressure, truncates packets longer than MAX_WORDS and reports
// per-packet length/status.
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   mac (slave)         : MAC receive stream (valid/ready, sop/eop, error, data)
//   wrfull              : FIFO full flag
//   wrreq, wrdata       : FIFO write strobe and word (combinational, zero latency)
//   pkt_done            : one-cycle pulse the cycle after a packet's closing write
//   pkt_len, pkt_err    : length / status of the last closed packet
//   pkt_cnt, drop_cnt   : saturating good / errored packet counters
// Build option:
//   RX_STATS_EN         : when defined, pkt_cnt/drop_cnt counters are built;
//                         otherwise both are tied to zero.
module mac_rx_writer #(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 380,
   parameter int LEN_W     = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   mac_rx_writer_if.slave    mac,
   input  logic              wrfull,
   output logic              wrreq,
   output logic [DATA_W+1:0] wrdata,
   output logic              pkt_done,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              pkt_err,
   output logic [LEN_W-1:0]  pkt_cnt,
   output logic [LEN_W-1:0]  drop_cnt
);

   typedef enum logic [1:0] {IDLE, RECEIVE, DROP} state_t;

   typedef struct packed {
      logic              err;
      logic              eop;
      logic [DATA_W-1:0] data;
   } fifo_word_t;

   state_t           state, next_state;
   logic [LEN_W-1:0] count, len_next;
   logic             ready, accept, wr_en, close, close_err;
   fifo_word_t       word;

   always_comb begin
      // DROP swallows beats regardless of FIFO state.
      ready      = (state == DROP) || !wrfull;
      accept     = mac.mac_valid && ready;
      wr_en      = 1'b0;
      close      = 1'b0;
      close_err  = 1'b0;
      next_state = state;
      len_next   = count + LEN_W'(1);
      case (state)
         IDLE: begin
            len_next = LEN_W'(1);
            if (accept && mac.mac_sop) begin
               wr_en = 1'b1;
               if (mac.mac_eop) begin
                  close     = 1'b1;
                  close_err = mac.mac_error;
               end else begin
                  next_state = RECEIVE;
               end
            end
         end
         RECEIVE: begin
            if (accept) begin
               wr_en = 1'b1;
               // Order matters: sop > eop > error > length limit.
               if (mac.mac_sop) begin
                  // Previous packet lost its eop; terminate it, lose the new one.
                  close      = 1'b1;
                  close_err  = 1'b1;
                  next_state = DROP;
               end else if (mac.mac_eop) begin
                  close      = 1'b1;
                  close_err  = mac.mac_error;
                  next_state = IDLE;
               end else if (mac.mac_error) begin
                  close      = 1'b1;
                  close_err  = 1'b1;
                  next_state = DROP;
               end else if (count == LEN_W'(MAX_WORDS - 1)) begin
                  // This beat is word MAX_WORDS: force truncation.
                  close      = 1'b1;
                  close_err  = 1'b1;
                  next_state = DROP;
               end
            end
         end
         DROP: begin
            if (accept && mac.mac_eop) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      word.err  = close_err;
      word.eop  = close;
      word.data = mac.mac_data;
   end

   assign mac.mac_ready = ready;
   assign wrreq         = wr_en;
   assign wrdata        = wr_en ? word : '0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         count    <= '0;
         pkt_done <= 1'b0;
         pkt_len  <= '0;
         pkt_err  <= 1'b0;
      end else begin
         state    <= next_state;
         pkt_done <= close;
         if (wr_en) count <= len_next;
         if (close) begin
            pkt_len <= len_next;
            pkt_err <= close_err;
         end
      end
   end

`ifdef RX_STATS_EN
   logic [LEN_W-1:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else if (close) begin
         if (!close_err && pkt_cnt_q != '1)  pkt_cnt_q  <= pkt_cnt_q + LEN_W'(1);
         if (close_err && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + LEN_W'(1);
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;
`else
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_rx_writer.sv
module tb_mac_rx_writer;
   localparam int DW   = 32;
   localparam int MW   = 4;
   localparam int LW   = 4;
   localparam int MAXC = (1 << LW) - 1;
`ifdef RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          wrfull = 1'b0;
   logic          wrreq;
   logic [DW+1:0] wrdata;
   logic          pkt_done;
   logic [LW-1:0] pkt_len;
   logic          pkt_err;
   logic [LW-1:0] pkt_cnt;
   logic [LW-1:0] drop_cnt;

   mac_rx_writer_if #(.DATA_W(DW)) bus ();

   mac_rx_writer #(.DATA_W(DW), .MAX_WORDS(MW), .LEN_W(LW)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .mac      (bus),
      .wrfull   (wrfull),
      .wrreq    (wrreq),
      .wrdata   (wrdata),
      .pkt_done (pkt_done),
      .pkt_len  (pkt_len),
      .pkt_err  (pkt_err),
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int proto_bad = 0;
   int cyc = 0;

   logic [DW+1:0] dut_wr[$], exp_wr[$];
   int            dut_wr_cyc[$];
   logic [LW:0]   dut_stat[$], exp_stat[$];

   // Reference model: mode 0 = waiting for sop, 1 = inside packet, 2 = discarding
   int m_mode, m_len, m_last_len, m_pkt, m_drop;
   bit m_last_err, m_done_pend;

   bit            obs_ready, obs_wrreq, obs_done, obs_err;
   logic [LW-1:0] obs_len;

   task automatic model_clear();
      m_mode = 0; m_len = 0; m_last_len = 0; m_last_err = 0;
      m_done_pend = 0; m_pkt = 0; m_drop = 0;
      dut_wr.delete(); exp_wr.delete(); dut_wr_cyc.delete();
      dut_stat.delete(); exp_stat.delete();
   endtask

   // One clock cycle: drive a beat, sample outputs mid-cycle, advance the model.
   task automatic step(input bit v, input bit s, input bit e, input bit er,
                       input logic [DW-1:0] d, input bit full);
      bit exp_ready, acc, wr, cl, cerr;
      bus.mac_valid = v; bus.mac_sop = s; bus.mac_eop = e;
      bus.mac_error = er; bus.mac_data = d; wrfull = full;
      @(negedge clk);
      obs_ready = bus.mac_ready; obs_wrreq = wrreq;
      obs_done = pkt_done; obs_len = pkt_len; obs_err = pkt_err;
      exp_ready = (m_mode == 2) || !full;
      if (obs_ready !== exp_ready) proto_bad++;
      if (wrreq === 1'b1 && full) proto_bad++;
      if (pkt_done !== m_done_pend || pkt_len !== LW'(m_last_len) || pkt_err !== m_last_err) proto_bad++;
      if (pkt_cnt !== (STATS ? LW'(m_pkt) : LW'(0))) proto_bad++;
      if (drop_cnt !== (STATS ? LW'(m_drop) : LW'(0))) proto_bad++;
      if (wrreq === 1'b1) begin dut_wr.push_back(wrdata); dut_wr_cyc.push_back(cyc); end
      if (pkt_done === 1'b1) dut_stat.push_back({pkt_err, pkt_len});
      acc = v && exp_ready; wr = 0; cl = 0; cerr = 0;
      if (m_mode == 0) begin
         if (acc && s) begin
            wr = 1; m_len = 1;
            if (e) begin cl = 1; cerr = er; end else m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (acc) begin
            wr = 1; m_len++;
            if (s)            begin cl = 1; cerr = 1;  m_mode = 2; end
            else if (e)       begin cl = 1; cerr = er; m_mode = 0; end
            else if (er)      begin cl = 1; cerr = 1;  m_mode = 2; end
            else if (m_len == MW) begin cl = 1; cerr = 1; m_mode = 2; end
         end
      end else begin
         if (acc && e) m_mode = 0;
      end
      if (wr) exp_wr.push_back({cerr, cl, d});
      m_done_pend = cl;
      if (cl) begin
         m_last_len = m_len; m_last_err = cerr;
         exp_stat.push_back({cerr, LW'(m_len)});
         if (cerr) begin if (m_drop < MAXC) m_drop++; end
         else begin if (m_pkt < MAXC) m_pkt++; end
      end
      @(posedge clk); #1; cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
   endtask

   task automatic do_reset();
      bus.mac_valid = 0; bus.mac_sop = 0; bus.mac_eop = 0; bus.mac_error = 0;
      bus.mac_data = '0; wrfull = 0;
      n_rst = 0;
      model_clear();
      @(posedge clk); #1;
      n_rst = 1;
   endtask

   task automatic test_reset();
      bus.mac_valid = 0; bus.mac_sop = 0; bus.mac_eop = 0; bus.mac_error = 0;
      bus.mac_data = 32'h1234_5678; wrfull = 0; n_rst = 0;
      #3;
      n_cmp++; if (bus.mac_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_empty: got %b want 1", bus.mac_ready); end
      n_cmp++; if (wrreq !== 1'b0) begin n_bad++; $display("FAIL rst_wrreq: got %b want 0", wrreq); end
      n_cmp++; if (wrdata !== '0) begin n_bad++; $display("FAIL rst_wrdata: got %h want 0", wrdata); end
      n_cmp++; if ({pkt_done, pkt_err, pkt_len} !== '0) begin n_bad++; $display("FAIL rst_status: got done=%b err=%b len=%0d want 0", pkt_done, pkt_err, pkt_len); end
      n_cmp++; if ({pkt_cnt, drop_cnt} !== '0) begin n_bad++; $display("FAIL rst_counters: got %0d/%0d want 0/0", pkt_cnt, drop_cnt); end
      wrfull = 1; #1;
      n_cmp++; if (bus.mac_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_full: got %b want 0", bus.mac_ready); end
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_four_beat();
      int pb = proto_bad;
      do_reset();
      step(1, 1, 0, 0, 32'hA000_0000, 0);
      step(1, 0, 0, 0, 32'hA000_0001, 0);
      step(1, 0, 0, 0, 32'hA000_0002, 0);
      step(1, 0, 1, 0, 32'hA000_0003, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 4) begin n_bad++; $display("FAIL four_nwr: got %0d want 4", dut_wr.size()); end
      else begin
         n_cmp++; if (dut_wr_cyc[3] - dut_wr_cyc[0] != 3) begin n_bad++; $display("FAIL four_consec: got span %0d want 3", dut_wr_cyc[3] - dut_wr_cyc[0]); end
         n_cmp++; if (dut_wr[3] !== {2'b01, 32'hA000_0003}) begin n_bad++; $display("FAIL four_last: got %h want %h", dut_wr[3], {2'b01, 32'hA000_0003}); end
      end
      n_cmp++; if (obs_done !== 1'b1 || obs_len !== 4'd4 || obs_err !== 1'b0) begin n_bad++; $display("FAIL four_status: got done=%b len=%0d err=%b want 1/4/0", obs_done, obs_len, obs_err); end
      n_cmp++; if (pkt_cnt !== (STATS ? 4'd1 : 4'd0)) begin n_bad++; $display("FAIL four_pkt_cnt: got %0d want %0d", pkt_cnt, STATS ? 1 : 0); end
      n_cmp++; if (proto_bad != pb) begin n_bad++; $display("FAIL four_protocol: got %0d want 0", proto_bad - pb); end
   endtask

   task automatic test_single();
      do_reset();
      step(1, 1, 1, 0, 32'hDEAD_BEEF, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 1 || dut_wr[0] !== {2'b01, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL single_word: got n=%0d w=%h want 1 %h", dut_wr.size(), dut_wr.size() ? dut_wr[0] : '0, {2'b01, 32'hDEAD_BEEF}); end
      n_cmp++; if (obs_done !== 1'b1 || obs_len !== 4'd1) begin n_bad++; $display("FAIL single_len: got done=%b len=%0d want 1/1", obs_done, obs_len); end
   endtask

   task automatic test_backpressure();
      int pb = proto_bad;
      do_reset();
      step(1, 1, 0, 0, 32'hB0, 0);
      step(1, 0, 0, 0, 32'hB1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 32'hB2, 1);
         n_cmp++; if (obs_ready !== 1'b0 || obs_wrreq !== 1'b0) begin n_bad++; $display("FAIL bp_stall%0d: got ready=%b wrreq=%b want 0/0", i, obs_ready, obs_wrreq); end
      end
      step(1, 0, 0, 0, 32'hB2, 0);
      step(1, 0, 1, 0, 32'hB3, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 4 || dut_wr[2] !== {2'b00, 32'hB2} || dut_wr[3] !== {2'b01, 32'hB3}) begin n_bad++; $display("FAIL bp_words: got n=%0d want 4 ending B2,B3", dut_wr.size()); end
      n_cmp++; if (obs_len !== 4'd4 || obs_err !== 1'b0) begin n_bad++; $display("FAIL bp_len: got len=%0d err=%b want 4/0", obs_len, obs_err); end
      n_cmp++; if (proto_bad != pb) begin n_bad++; $display("FAIL bp_protocol: got %0d want 0", proto_bad - pb); end
   endtask

   task automatic test_error();
      do_reset();
      step(1, 1, 0, 0, 32'hC0, 0);
      step(1, 0, 0, 0, 32'hC1, 0);
      step(1, 0, 0, 1, 32'hC2, 0);
      for (int i = 3; i < 6; i++) begin
         step(1, 0, i == 5, 0, 32'hC0 + i, 1);
         n_cmp++; if (obs_ready !== 1'b1 || obs_wrreq !== 1'b0) begin n_bad++; $display("FAIL err_drop%0d: got ready=%b wrreq=%b want 1/0", i, obs_ready, obs_wrreq); end
         if (i == 3) begin
            n_cmp++; if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_len !== 4'd3) begin n_bad++; $display("FAIL err_status: got done=%b err=%b len=%0d want 1/1/3", obs_done, obs_err, obs_len); end
         end
      end
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 3 || dut_wr[2] !== {2'b11, 32'hC2}) begin n_bad++; $display("FAIL err_words: got n=%0d want 3 ending %h", dut_wr.size(), {2'b11, 32'hC2}); end
      n_cmp++; if (drop_cnt !== (STATS ? 4'd1 : 4'd0) || pkt_cnt !== 4'd0) begin n_bad++; $display("FAIL err_counts: got drop=%0d pkt=%0d want %0d/0", drop_cnt, pkt_cnt, STATS ? 1 : 0); end
   endtask

   task automatic test_truncate();
      int pb = proto_bad;
      do_reset();
      for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, 0, 32'hD0 + i, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 4 || dut_wr[3] !== {2'b11, 32'hD3} || dut_wr[2][DW] !== 1'b0) begin n_bad++; $display("FAIL trunc_words: got n=%0d want 4 ending %h", dut_wr.size(), {2'b11, 32'hD3}); end
      n_cmp++; if (pkt_len !== 4'd4 || pkt_err !== 1'b1) begin n_bad++; $display("FAIL trunc_len: got len=%0d err=%b want 4/1", pkt_len, pkt_err); end
      step(1, 1, 0, 0, 32'hE0, 0);
      step(1, 0, 1, 0, 32'hE1, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 6 || dut_wr[5] !== {2'b01, 32'hE1}) begin n_bad++; $display("FAIL trunc_next: got n=%0d want 6 ending %h", dut_wr.size(), {2'b01, 32'hE1}); end
      n_cmp++; if (obs_len !== 4'd2 || obs_err !== 1'b0) begin n_bad++; $display("FAIL trunc_next_len: got len=%0d err=%b want 2/0", obs_len, obs_err); end
      n_cmp++; if (proto_bad != pb) begin n_bad++; $display("FAIL trunc_protocol: got %0d want 0", proto_bad - pb); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1, 1, 1, 0, 32'hF0, 0);
      step(1, 1, 0, 0, 32'hF1, 0);
      step(1, 0, 0, 0, 32'hF2, 0);
      bus.mac_valid = 0; n_rst = 0; #1;
      n_cmp++; if ({wrreq, pkt_done, pkt_err, pkt_len} !== '0 || wrdata !== '0) begin n_bad++; $display("FAIL rmid_outputs: got wrreq=%b done=%b err=%b len=%0d wrdata=%h want 0", wrreq, pkt_done, pkt_err, pkt_len, wrdata); end
      n_cmp++; if ({pkt_cnt, drop_cnt} !== '0 || bus.mac_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_counters: got %0d/%0d ready=%b want 0/0/1", pkt_cnt, drop_cnt, bus.mac_ready); end
      do_reset();
      step(1, 0, 0, 0, 32'hF3, 0);
      n_cmp++; if (obs_wrreq !== 1'b0) begin n_bad++; $display("FAIL rmid_nosop: got wrreq=%b want 0", obs_wrreq); end
      step(1, 1, 0, 0, 32'hF4, 0);
      n_cmp++; if (obs_wrreq !== 1'b1) begin n_bad++; $display("FAIL rmid_sop: got wrreq=%b want 1", obs_wrreq); end
      step(1, 0, 1, 0, 32'hF5, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (obs_done !== 1'b1 || obs_len !== 4'd2 || dut_wr.size() != 2) begin n_bad++; $display("FAIL rmid_pkt: got done=%b len=%0d n=%0d want 1/2/2", obs_done, obs_len, dut_wr.size()); end
   endtask

   task automatic test_back_to_back();
      int pb = proto_bad;
      do_reset();
      step(1, 1, 0, 0, 32'h10, 0); step(1, 0, 1, 0, 32'h11, 0);
      step(1, 1, 0, 0, 32'h20, 0); step(1, 0, 0, 0, 32'h21, 0); step(1, 0, 1, 0, 32'h22, 0);
      step(1, 1, 1, 0, 32'h30, 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (dut_wr.size() != 6 || dut_wr_cyc[5] - dut_wr_cyc[0] != 5) begin n_bad++; $display("FAIL b2b_nwr: got n=%0d want 6 contiguous", dut_wr.size()); end
      n_cmp++; if (dut_stat.size() != 3 || dut_stat[1] !== {1'b0, 4'd3}) begin n_bad++; $display("FAIL b2b_stat: got n=%0d want 3 with second len 3", dut_stat.size()); end
      n_cmp++; if (pkt_cnt !== (STATS ? 4'd3 : 4'd0)) begin n_bad++; $display("FAIL b2b_pkt_cnt: got %0d want %0d", pkt_cnt, STATS ? 3 : 0); end
      n_cmp++; if (proto_bad != pb) begin n_bad++; $display("FAIL b2b_protocol: got %0d want 0", proto_bad - pb); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 18; i++) step(1, 1, 1, 0, 32'(i), 0);
      for (int i = 0; i < 17; i++) step(1, 1, 1, 1, 32'(i), 0);
      step(0, 0, 0, 0, '0, 0);
      n_cmp++; if (pkt_cnt !== (STATS ? 4'd15 : 4'd0)) begin n_bad++; $display("FAIL sat_pkt_cnt: got %0d want %0d", pkt_cnt, STATS ? 15 : 0); end
      n_cmp++; if (drop_cnt !== (STATS ? 4'd15 : 4'd0)) begin n_bad++; $display("FAIL sat_drop_cnt: got %0d want %0d", drop_cnt, STATS ? 15 : 0); end
   endtask

   task automatic test_random();
      int pb = proto_bad;
      int nbad_w = 0, nbad_s = 0;
      bit s, e;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(99) < 15);
         e = ($urandom_range(99) < 20);
         step($urandom_range(99) < 70, s, e, !s && ($urandom_range(99) < 6),
              $urandom, $urandom_range(99) < 25);
      end
      idle(2);
      n_cmp++; if (dut_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL rnd_nwr: got %0d want %0d", dut_wr.size(), exp_wr.size()); end
      else begin
         foreach (exp_wr[k]) if (dut_wr[k] !== exp_wr[k]) nbad_w++;
         n_cmp++; if (nbad_w != 0) begin n_bad++; $display("FAIL rnd_words: got %0d differing words want 0", nbad_w); end
      end
      n_cmp++; if (dut_stat.size() != exp_stat.size()) begin n_bad++; $display("FAIL rnd_nstat: got %0d want %0d", dut_stat.size(), exp_stat.size()); end
      else begin
         foreach (exp_stat[k]) if (dut_stat[k] !== exp_stat[k]) nbad_s++;
         n_cmp++; if (nbad_s != 0) begin n_bad++; $display("FAIL rnd_stat: got %0d differing records want 0", nbad_s); end
      end
      n_cmp++; if (proto_bad != pb) begin n_bad++; $display("FAIL rnd_protocol: got %0d cycle errors want 0", proto_bad - pb); end
   endtask

   initial begin
      test_reset();
      test_four_beat();
      test_single();
      test_backpressure();
      test_error();
      test_truncate();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mac_rx_writer.md
# mac_rx_writer

Receive-side writer for the sniffer's input FIFO. It accepts the MAC's streaming receive interface (valid/ready, sop/eop, error) and packs each beat into a FIFO word tagged with end-of-packet and error flags. It applies backpressure when the FIFO is full and truncates oversize packets. It reports per-packet length and status to the controller that drains the FIFO.

## Interface
Parameters:
- DATA_W, 32, data beat width in bits.
- MAX_WORDS, 380, maximum words written per packet before forced truncation (≥2).
- LEN_W, 16, width of the length and statistics counters.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- mac_valid  in  1  MAC beat valid.
- mac_sop  in  1  first beat of a packet.
- mac_eop  in  1  last beat of a packet.
- mac_error  in  1  MAC error flag; meaningful on any beat.
- mac_data  in  DATA_W  beat payload.
- mac_ready  out  1  beat accepted when mac_valid && mac_ready.
- wrfull  in  1  input FIFO full flag.
- wrreq  out  1  FIFO write strobe.
- wrdata  out  DATA_W+2  FIFO word, packed as {err, eop, data}.
- pkt_done  out  1  one-cycle pulse when a packet's final word has been written.
- pkt_len  out  LEN_W  number of words in the last completed packet.
- pkt_err  out  1  error/truncation status of the last completed packet.
- pkt_cnt  out  LEN_W  packets completed without error; saturating.
- drop_cnt  out  LEN_W  packets closed with err=1; saturating.

## Operation
States: IDLE, RECEIVE, DROP.
- A beat is **accepted** when mac_valid && mac_ready.
- mac_ready = 1 in DROP; otherwise mac_ready = !wrfull.

IDLE:
- Accepted beat without sop: discarded, no write.
- Accepted beat with sop: written, and the word count is set to 1.
  - With eop also set: the packet completes here and the state stays IDLE.
  - Otherwise: go to RECEIVE.

RECEIVE (every accepted beat is written and the count increments):
- eop: write with eop=1 and err=mac_error, then go to IDLE.
- mac_error without eop: write with err=1, eop=1, then go to DROP.
- The beat that brings the count to MAX_WORDS without eop: write with err=1, eop=1, then go to DROP.
- sop (missing eop on the previous packet): write the beat as err=1, eop=1 to terminate the previous packet, then go to DROP. The new packet is lost.
- Priority when several conditions hold on one beat: sop > eop > error > length limit.

DROP:
- Accept and discard all beats.
- An accepted beat with eop returns the state to IDLE.
- No writes are issued in DROP.

Write and status rules:
- wrreq = accepted && state ∈ {IDLE with sop, RECEIVE}. It is combinational from the accept condition.
- wrdata is combinational from the accepted beat.
- A written word with eop=1 closes the packet:
  - On the next edge, pkt_done pulses for one cycle.
  - pkt_len and pkt_err are loaded with that packet's values and held until the next close.
  - pkt_cnt increments if err=0; drop_cnt increments if err=1.
- Counters saturate at 2^LEN_W−1 and do not wrap.
- A packet that is closed and then drained in DROP is counted once.

## Timing
- Reset values: state IDLE; wrreq 0; pkt_done 0; pkt_len 0; pkt_err 0; pkt_cnt 0; drop_cnt 0.
- Reset values of combinational outputs: wrdata 0, and mac_ready = !wrfull.
- Write latency: zero. wrreq is asserted in the same cycle as the accepted beat.
- Status latency: pkt_done, pkt_len and pkt_err update exactly 1 cycle after the closing write.
- wrreq is never asserted while wrfull=1.
- Back-to-back packets are supported: an eop beat followed by a sop beat on the next cycle loses no beat.
- Reset mid-packet: return to IDLE immediately. The FIFO holds an unterminated packet; the system reset must also clear the FIFO.

## Configuration
- RX_STATS_EN defined: pkt_cnt and drop_cnt are implemented as described.
- RX_STATS_EN undefined: pkt_cnt and drop_cnt are tied to 0 and no counter flops are built. pkt_len, pkt_err and pkt_done remain implemented.

## Test plan
- 4-beat packet (sop on beat 0, eop on beat 3), wrfull=0:
  - wrreq asserted on 4 consecutive cycles; last wrdata has eop=1, err=0.
  - pkt_done pulses 1 cycle after the last write with pkt_len=4, pkt_err=0; pkt_cnt=1.
- Single beat with sop=eop=1, data 0xDEADBEEF:
  - one write of {0,1,0xDEADBEEF}; pkt_len=1.
- wrfull=1 for 3 cycles mid-packet:
  - mac_ready=0 and wrreq=0 during those cycles; no beat lost; pkt_len equals the number of beats sent.
- mac_error on beat 2 of a 6-beat packet:
  - 3 words written, the third with err=1, eop=1.
  - Beats 3–5 are discarded with mac_ready=1.
  - pkt_err=1, drop_cnt=1.
- MAX_WORDS=4 with a 10-beat packet:
  - 4 writes; word 4 has err=1, eop=1; the rest are discarded; pkt_len=4.
  - The next packet is received normally.
- Reset asserted in RECEIVE:
  - all outputs return to their reset values.
  - A following non-sop beat is discarded; a following sop beat starts a new packet.
